// File: rtl/shift_req_arbiter.sv
// -----------------------------------------------------------------------------
// shift_req_arbiter
//   Shares one pipelined shifter among NUM_REQ requesters. Requests are
//   arbitrated with valid/ready, at most one op per cycle is issued to the
//   shifter through registered sh_* outputs, and a tag pipeline of
//   {valid, id} runs alongside the shifter. When a tag reaches the tail, the
//   result is returned on rsp_* together with the id of the requester that
//   owns it.
//
//   Optional feature macro: SHARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest index wins (ptr stays 0)
//     undefined -> round-robin, starting the search at ptr
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   ctrl_en       1 = grants allowed, 0 = no new grants (in-flight ops drain)
//   req_valid     per-requester request valid
//   req_ready     per-requester grant (one-hot or zero, combinational)
//   req_data      flattened operands, requester i at [i*DATA_W +: DATA_W]
//   req_amt       flattened shift amounts, requester i at [i*AMT_W +: AMT_W]
//   req_right     per-requester direction (1 = right)
//   sh_valid      op issued to the shifter this cycle
//   sh_data_in    shifter operand
//   sh_amount     shifter amount
//   sh_right      shifter direction
//   sh_data_out   shifter result, valid PIPE_LAT cycles after issue
//   rsp_valid     single-cycle result pulse
//   rsp_id        requester owning rsp_data
//   rsp_data      shifted result
//   busy          an op is issued but not yet returned
// -----------------------------------------------------------------------------
module shift_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int AMT_W    = 2,
  parameter int PIPE_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
  input  logic [NUM_REQ-1:0]        req_right,
  output logic                      sh_valid,
  output logic [DATA_W-1:0]         sh_data_in,
  output logic [AMT_W-1:0]          sh_amount,
  output logic                      sh_right,
  input  logic [DATA_W-1:0]         sh_data_out,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic                         sh_valid_q, sh_valid_d;
  logic [DATA_W-1:0]            sh_data_q, sh_data_d;
  logic [AMT_W-1:0]             sh_amt_q, sh_amt_d;
  logic                         sh_right_q, sh_right_d;
  logic [PIPE_LAT:0]            tag_vld_q, tag_vld_d;
  logic [PIPE_LAT:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]           grant;
  logic                         gnt_any;
  logic [ID_W-1:0]              gnt_id;
  logic [DATA_W-1:0]            sel_data;
  logic [AMT_W-1:0]             sel_amt;
  logic                         sel_right;

  // Arbitration: scan ptr, ptr+1, ... (mod NUM_REQ); first valid wins.
  // With ptr held at 0 this degenerates into lowest-index-wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    sel_data  = '0;
    sel_amt   = '0;
    sel_right = 1'b0;
    if (ctrl_en && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!gnt_any && req_valid[idx]) begin
          grant[idx] = 1'b1;
          gnt_any    = 1'b1;
          gnt_id     = ID_W'(idx);
          sel_data   = req_data[idx*DATA_W +: DATA_W];
          sel_amt    = req_amt[idx*AMT_W +: AMT_W];
          sel_right  = req_right[idx];
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
`ifdef SHARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
`endif
  end

  // Issue stage: operands only change on a grant so the shifter input is stable
  always_comb begin
    sh_valid_d = gnt_any;
    sh_data_d  = gnt_any ? sel_data  : sh_data_q;
    sh_amt_d   = gnt_any ? sel_amt   : sh_amt_q;
    sh_right_d = gnt_any ? sel_right : sh_right_q;
  end

  // Tag pipe: stage 0 lines up with sh_*, stage PIPE_LAT with sh_data_out
  always_comb begin
    tag_vld_d   = {tag_vld_q[PIPE_LAT-1:0], gnt_any};
    tag_id_d    = tag_id_q;
    tag_id_d[0] = gnt_id;
    for (int k = 1; k <= PIPE_LAT; k++) begin
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  // Response stage: capture result at the tag tail, hold otherwise
  always_comb begin
    rsp_valid_d = tag_vld_q[PIPE_LAT];
    rsp_id_d    = tag_vld_q[PIPE_LAT] ? tag_id_q[PIPE_LAT] : rsp_id_q;
    rsp_data_d  = tag_vld_q[PIPE_LAT] ? sh_data_out        : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      sh_valid_q  <= 1'b0;
      sh_data_q   <= '0;
      sh_amt_q    <= '0;
      sh_right_q  <= 1'b0;
      tag_vld_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      sh_valid_q  <= sh_valid_d;
      sh_data_q   <= sh_data_d;
      sh_amt_q    <= sh_amt_d;
      sh_right_q  <= sh_right_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Tag ids are qualified by tag_vld_q, so they need no reset
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
  end

  assign sh_valid   = sh_valid_q;
  assign sh_data_in = sh_data_q;
  assign sh_amount  = sh_amt_q;
  assign sh_right   = sh_right_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = sh_valid_q | (|tag_vld_q);

endmodule

// File: tb/tb_shift_req_arbiter.sv
module tb_shift_req_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int AMT_W    = 2;
  localparam int PIPE_LAT = 2;
  localparam int ID_W     = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      ctrl_en = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ*AMT_W-1:0]  req_amt = '0;
  logic [NUM_REQ-1:0]        req_right = '0;
  logic                      sh_valid;
  logic [DATA_W-1:0]         sh_data_in;
  logic [AMT_W-1:0]          sh_amount;
  logic                      sh_right;
  logic [DATA_W-1:0]         sh_data_out;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  shift_req_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .AMT_W(AMT_W),
    .PIPE_LAT(PIPE_LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_right(req_right),
    .sh_valid(sh_valid), .sh_data_in(sh_data_in), .sh_amount(sh_amount),
    .sh_right(sh_right), .sh_data_out(sh_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] shift_ref(input logic [DATA_W-1:0] d,
                                                  input logic [AMT_W-1:0] a,
                                                  input logic r);
    return r ? (d >> a) : (d << a);
  endfunction

  // Shifter model: PIPE_LAT register stages of the logical shift result
  logic [DATA_W-1:0] shp [PIPE_LAT];
  always @(posedge clk) begin
    shp[0] <= shift_ref(sh_data_in, sh_amount, sh_right);
    for (int k = 1; k < PIPE_LAT; k++) shp[k] <= shp[k-1];
  end
  assign sh_data_out = shp[PIPE_LAT-1];

  typedef struct {
    int              id;
    logic [DATA_W-1:0] d;
    int              cyc;
  } exp_t;

  exp_t sbq[$];
  int   glog_id[$];
  int   glog_cyc[$];
  int   last_hs_cyc = -100;

  // Monitor: score responses, then log handshakes, then apply reset flush
  always @(negedge clk) begin
    exp_t e;
    chk("ready_onehot", 32'($countones(req_ready) > 1), 0);
    chk("ready_wo_valid", 32'(|(req_ready & ~req_valid)), 0);
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_latency", 32'(cyc - e.cyc), 32'(PIPE_LAT + 2));
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id  = i;
        e.d   = shift_ref(req_data[i*DATA_W +: DATA_W], req_amt[i*AMT_W +: AMT_W], req_right[i]);
        e.cyc = cyc;
        sbq.push_back(e);
        glog_id.push_back(i);
        glog_cyc.push_back(cyc);
        last_hs_cyc = cyc;
      end
    end
    if (rst) sbq.delete();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] d,
                         input logic [AMT_W-1:0] a, input logic r);
    req_data[i*DATA_W +: DATA_W] = d;
    req_amt[i*AMT_W +: AMT_W]    = a;
    req_right[i]                 = r;
  endtask

  // Requesters drop valid once granted; bounded
  task automatic run_drop(input int max_cyc);
    logic [NUM_REQ-1:0] hs;
    int n;
    n = 0;
    while (req_valid != '0 && n < max_cyc) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs;
      n++;
    end
    if (req_valid != '0) chk("grant_timeout", 32'(req_valid), 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain", 32'(sbq.size()), 0);
    tick();
  endtask

  task automatic clear_log();
    glog_id.delete();
    glog_cyc.delete();
  endtask

  task automatic check_grants(input string tag, input int ids[$]);
    chk({tag, "_count"}, 32'(glog_id.size()), 32'(ids.size()));
    for (int i = 0; i < ids.size() && i < glog_id.size(); i++) begin
      chk({tag, "_id"}, 32'(glog_id[i]), 32'(ids[i]));
      if (i > 0) chk({tag, "_gap"}, 32'(glog_cyc[i] - glog_cyc[i-1]), 1);
    end
  endtask

  initial begin
    int ids[$];

    // Reset state, with all requests asserted
    rst = 1'b1;
    req_valid = '1;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_sh_valid", 32'(sh_valid), 0);
    chk("rst_sh_data", 32'(sh_data_in), 0);
    chk("rst_sh_amt", 32'(sh_amount), 0);
    chk("rst_sh_right", 32'(sh_right), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // 1: single request from req0, A5 << 1 = 4A
    clear_log();
    set_req(0, 8'hA5, 2'd1, 1'b0);
    req_valid = 4'b0001;
    run_drop(10);
    wait_drain();
    chk("t1_rsp_data", 32'(rsp_data), 32'h4A);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    ids = '{0};
    check_grants("t1_gnt", ids);

    // 2: all four at once after reset of the pointer, A5 >> 1 = 52
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'hA5, 2'd1, 1'b1);
    req_valid = '1;
    run_drop(10);
    wait_drain();
    chk("t2_rsp_data", 32'(rsp_data), 32'h52);
    chk("t2_rsp_id", 32'(rsp_id), 3);
    ids = '{0, 1, 2, 3};
    check_grants("t2_gnt", ids);

    // 3: req1 and req3 held continuously alternate without idle cycles
    clear_log();
    set_req(1, 8'h81, 2'd2, 1'b0);
    set_req(3, 8'h3C, 2'd3, 1'b1);
    req_valid = 4'b1010;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();
    ids = '{1, 3, 1, 3, 1, 3, 1, 3};
    check_grants("t3_gnt", ids);

    // 4: ctrl_en drop blocks grants, in-flight ops drain, busy falls
    clear_log();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h11 * (i + 3)), 2'(i), 1'(i & 1));
    req_valid = '1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    ctrl_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t4_ready", 32'(req_ready), 0);
      chk("t4_sh_valid", 32'(sh_valid), 32'(cyc == last_hs_cyc + 1));
      chk("t4_busy", 32'(busy), 32'(cyc <= last_hs_cyc + PIPE_LAT + 1));
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    ctrl_en = 1'b1;
    wait_drain();
    ids = '{0, 1, 2};
    check_grants("t4_gnt", ids);

    // 5: reset with two ops in flight flushes them and rewinds the pointer
    clear_log();
    set_req(0, 8'hF0, 2'd1, 1'b1);
    set_req(1, 8'h0F, 2'd2, 1'b0);
    req_valid = 4'b0011;
    run_drop(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_sh_valid", 32'(sh_valid), 0);
    chk("t5_sh_data", 32'(sh_data_in), 0);
    chk("t5_sh_amt", 32'(sh_amount), 0);
    chk("t5_sh_right", 32'(sh_right), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_rsp_id", 32'(rsp_id), 0);
    chk("t5_rsp_data", 32'(rsp_data), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_flushed", 32'(sbq.size()), 0);
    repeat (5) tick();
    set_req(2, 8'h5A, 2'd2, 1'b1);
    req_valid = 4'b0101;
    @(negedge clk);
    chk("t5_first_gnt", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    run_drop(10);
    wait_drain();

    // 6: req0 and req2 held
    clear_log();
    req_valid = 4'b0101;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();
`ifdef SHARB_FIXED_PRIO_EN
    ids = '{0, 0, 0, 0, 0, 0};
`else
    ids = '{0, 2, 0, 2, 0, 2};
`endif
    check_grants("t6_gnt", ids);

    chk("end_queue_empty", 32'(sbq.size()), 0);
    chk("end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
